// File: rtl/tempsense_pkg.sv
// Shared types and constants for the temperature-sensor conversion scheduler.
package tempsense_pkg;

    localparam int unsigned VDAC_W        = 6;
    localparam int unsigned TICK_W        = 12;
    localparam int unsigned TIMEOUT_DEF   = 4095;
    localparam int unsigned START_LEN_DEF = 2;
    localparam int unsigned LEN_W         = 3;
    localparam int unsigned AVG_VDAC_W    = 8;
    localparam int unsigned AVG_TICK_W    = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        START   = 3'd2,
        CONV    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    typedef struct packed {
        logic [VDAC_W-1:0] vdac;
        logic [TICK_W-1:0] tick;
    } res_t;

endpackage

// File: rtl/tempsense_sched_cnt.sv
// Loadable saturating down-counter with a registered zero flag.
module tempsense_sched_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         r_zero;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load_i) begin
            w_cnt_nxt = val_i;
        end else if (dec_i && !r_zero) begin
            w_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_zero <= (w_cnt_nxt == '0);
        end
    end

    assign zero_o = r_zero;

endmodule

// File: rtl/tempsense_sched.sv
// Temperature-sensor conversion scheduler: periodic/one-shot starts, timeout, result handshake.
// Optional 4-sample averaging is enabled by defining TEMPSENSE_SCHED_AVG_EN.
module tempsense_sched
    import tempsense_pkg::*;
#(
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned START_LEN = START_LEN_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                single_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                start_conv_o,
    input  logic                conv_done_i,
    input  logic [VDAC_W-1:0]   vdac_i,
    input  logic [TICK_W-1:0]   tick_i,
    output logic [VDAC_W-1:0]   res_vdac_o,
    output logic [TICK_W-1:0]   res_tick_o,
    output logic                res_valid_o,
    input  logic                res_ack_i,
    output logic                overrun_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic                r_done_q;
    logic                w_done_edge;
    logic                w_per_zero;
    logic                w_len_zero;
    logic                w_to_zero;
    logic [PERIOD_W-1:0] w_per_m1;
    logic                w_start_entry;
    logic                w_conv_entry;
    logic                w_per_load;
    logic                w_timeout_hit;
    logic                w_emit;
    res_t                w_res_in;

    logic r_start, r_busy, r_valid, r_overrun, r_timeout;
    res_t r_res;
    logic w_start_nxt, w_busy_nxt, w_valid_nxt, w_overrun_nxt, w_timeout_nxt;
    res_t w_res_nxt;

    // Previous done level; resets high so a level present at reset is not an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_done_q <= 1'b1;
        end else begin
            r_done_q <= conv_done_i;
        end
    end

    assign w_done_edge   = conv_done_i & ~r_done_q;
    assign w_per_m1      = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    assign w_start_entry = (w_next == START) && (r_state != START);
    assign w_conv_entry  = (r_state == START) && (w_next == CONV);
    assign w_timeout_hit = (r_state == CONV) && !w_done_edge && w_to_zero;

    // Period runs start-to-start: reloaded on every start, and when periodic mode begins.
    assign w_per_load = w_start_entry || ((r_state == IDLE) && (w_next == WAIT));

    tempsense_sched_cnt #(.W(PERIOD_W)) u_per_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_per_load),
        .val_i   (w_per_m1),
        .dec_i   (1'b1),
        .zero_o  (w_per_zero)
    );

    tempsense_sched_cnt #(.W(LEN_W)) u_len_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_start_entry),
        .val_i   (LEN_W'(START_LEN - 1)),
        .dec_i   (r_state == START),
        .zero_o  (w_len_zero)
    );

    tempsense_sched_cnt #(.W(TO_W)) u_to_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_conv_entry),
        .val_i   (TO_W'(TIMEOUT - 1)),
        .dec_i   (r_state == CONV),
        .zero_o  (w_to_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (single_i) begin
                    w_next = START;
                end else if (en_i) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (single_i) begin
                    w_next = START;
                end else if (!en_i) begin
                    w_next = IDLE;
                end else if (w_per_zero) begin
                    w_next = START;
                end
            end
            START: begin
                if (w_len_zero) begin
                    w_next = CONV;
                end
            end
            CONV: begin
                if (w_done_edge) begin
                    w_next = CAPTURE;
                end else if (w_to_zero) begin
                    w_next = en_i ? WAIT : IDLE;
                end
            end
            CAPTURE: begin
                w_next = en_i ? WAIT : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef TEMPSENSE_SCHED_AVG_EN
    logic [AVG_VDAC_W-1:0] r_acc_vdac;
    logic [AVG_TICK_W-1:0] r_acc_tick;
    logic [1:0]            r_smp;
    logic [AVG_VDAC_W-1:0] w_vsum;
    logic [AVG_TICK_W-1:0] w_tsum;

    assign w_vsum   = r_acc_vdac + AVG_VDAC_W'(vdac_i);
    assign w_tsum   = r_acc_tick + AVG_TICK_W'(tick_i);
    assign w_emit   = (r_state == CAPTURE) && (r_smp == 2'd3);
    assign w_res_in = {VDAC_W'(w_vsum >> 2), TICK_W'(w_tsum >> 2)};

    // Accumulator restarts after every emitted average and on any timeout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc_vdac <= '0;
            r_acc_tick <= '0;
            r_smp      <= '0;
        end else if (w_timeout_hit || w_emit) begin
            r_acc_vdac <= '0;
            r_acc_tick <= '0;
            r_smp      <= '0;
        end else if (r_state == CAPTURE) begin
            r_acc_vdac <= w_vsum;
            r_acc_tick <= w_tsum;
            r_smp      <= r_smp + 2'd1;
        end
    end
`else
    assign w_emit   = (r_state == CAPTURE);
    assign w_res_in = {vdac_i, tick_i};
`endif

    // Next values of the registered outputs; a capture overrides a same-cycle ack.
    always_comb begin
        w_start_nxt   = (w_next == START);
        w_busy_nxt    = (w_next == START) || (w_next == CONV) || (w_next == CAPTURE);
        w_timeout_nxt = r_timeout;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        w_res_nxt     = r_res;
        if (w_timeout_hit) begin
            w_timeout_nxt = 1'b1;
        end
        if (r_state == CAPTURE) begin
            w_timeout_nxt = 1'b0;
        end
        if (r_valid && res_ack_i) begin
            w_valid_nxt   = 1'b0;
            w_overrun_nxt = 1'b0;
        end
        if (w_emit) begin
            w_res_nxt   = w_res_in;
            w_valid_nxt = 1'b1;
            if (r_valid && !res_ack_i) begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_res     <= '0;
        end else begin
            r_start   <= w_start_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
            r_timeout <= w_timeout_nxt;
            r_res     <= w_res_nxt;
        end
    end

    assign start_conv_o = r_start;
    assign busy_o       = r_busy;
    assign res_valid_o  = r_valid;
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;
    assign res_vdac_o   = r_res.vdac;
    assign res_tick_o   = r_res.tick;

endmodule

// File: tb/tb_tempsense_sched.sv
// Scoreboard bench for tempsense_sched: expected results queued at done, compared when a result appears.
module tb_tempsense_sched;
    import tempsense_pkg::*;

    localparam int unsigned PERIOD_W  = 16;
    localparam int unsigned TIMEOUT   = 4095;
    localparam int unsigned START_LEN = 2;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic                en_i;
    logic                single_i;
    logic [PERIOD_W-1:0] period_i;
    logic                start_conv_o;
    logic                conv_done_i;
    logic [VDAC_W-1:0]   vdac_i;
    logic [TICK_W-1:0]   tick_i;
    logic [VDAC_W-1:0]   res_vdac_o;
    logic [TICK_W-1:0]   res_tick_o;
    logic                res_valid_o;
    logic                res_ack_i;
    logic                overrun_o;
    logic                timeout_o;
    logic                busy_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    res_t        sb_q[$];
    logic        valid_q  = 1'b0;
    logic        ovr_q    = 1'b0;

    tempsense_sched #(
        .PERIOD_W  (PERIOD_W),
        .TIMEOUT   (TIMEOUT),
        .START_LEN (START_LEN)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .single_i     (single_i),
        .period_i     (period_i),
        .start_conv_o (start_conv_o),
        .conv_done_i  (conv_done_i),
        .vdac_i       (vdac_i),
        .tick_i       (tick_i),
        .res_vdac_o   (res_vdac_o),
        .res_tick_o   (res_tick_o),
        .res_valid_o  (res_valid_o),
        .res_ack_i    (res_ack_i),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A new result is a valid rise, or an overrun rise while valid stays high.
    always @(negedge clk_i) begin
        if (res_valid_o && (!valid_q || (overrun_o && !ovr_q))) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                check("res_vdac", 32'(res_vdac_o), 32'(sb_q[0].vdac));
                check("res_tick", 32'(res_tick_o), 32'(sb_q[0].tick));
                void'(sb_q.pop_front());
            end
        end
        valid_q <= res_valid_o;
        ovr_q   <= overrun_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_single();
        single_i = 1'b1;
        step(1);
        single_i = 1'b0;
    endtask

    task automatic wait_start_fall();
        int n = 0;
        while (start_conv_o && n < 32) begin
            step(1);
            n++;
        end
        check("start_fall_bound", 32'(start_conv_o), 0);
    endtask

    task automatic drive_done(input logic [VDAC_W-1:0] v, input logic [TICK_W-1:0] t, input bit push);
        res_t e;
        vdac_i      = v;
        tick_i      = t;
        conv_done_i = 1'b1;
        e.vdac      = v;
        e.tick      = t;
        if (push) sb_q.push_back(e);
    endtask

    task automatic ack();
        res_ack_i = 1'b1;
        step(1);
        res_ack_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},   32'(start_conv_o), 0);
        check({tag, "_busy"},    32'(busy_o), 0);
        check({tag, "_valid"},   32'(res_valid_o), 0);
        check({tag, "_overrun"}, 32'(overrun_o), 0);
        check({tag, "_timeout"}, 32'(timeout_o), 0);
        check({tag, "_vdac"},    32'(res_vdac_o), 0);
        check({tag, "_tick"},    32'(res_tick_o), 0);
    endtask

    // Waits for a periodic start, answers done 10 cycles after the pulse ends.
    task automatic respond(input logic [VDAC_W-1:0] v, input logic [TICK_W-1:0] t, output int t_rise);
        int n = 0;
        while (!start_conv_o && n < 200) begin
            step(1);
            n++;
        end
        check("per_start_bound", 32'(start_conv_o), 1);
        t_rise = int'(cyc);
        wait_start_fall();
        step(10);
        drive_done(v, t, 1'b1);
        step(2);
        conv_done_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int t_a;
        int t_b;
        rst_n_i     = 1'b0;
        en_i        = 1'b0;
        single_i    = 1'b0;
        period_i    = '0;
        conv_done_i = 1'b0;
        vdac_i      = '0;
        tick_i      = '0;
        res_ack_i   = 1'b0;
        step(3);
        check_all_zero("rst");
        rst_n_i = 1'b1;
        step(2);

`ifdef TEMPSENSE_SCHED_AVG_EN
        begin
            logic [TICK_W-1:0] tk [4];
            logic [VDAC_W-1:0] vd [4];
            res_t              avg;
            tk = '{12'd100, 12'd101, 12'd102, 12'd104};
            vd = '{6'd10, 6'd11, 6'd12, 6'd13};
            avg.vdac = 6'd11;
            avg.tick = 12'd101;
            for (int i = 0; i < 4; i++) begin
                pulse_single();
                wait_start_fall();
                step(4);
                drive_done(vd[i], tk[i], 1'b0);
                if (i == 3) sb_q.push_back(avg);
                step(2);
                check("avg_valid", 32'(res_valid_o), (i == 3) ? 1 : 0);
                conv_done_i = 1'b0;
                step(1);
            end
            ack();
            check("avg_ack", 32'(res_valid_o), 0);
        end
`else
        // One-shot: pulse width, busy, two-cycle result latency.
        pulse_single();
        check("t1_start_hi", 32'(start_conv_o), 1);
        check("t1_busy", 32'(busy_o), 1);
        step(1);
        check("t1_start_hi2", 32'(start_conv_o), 1);
        step(1);
        check("t1_start_lo", 32'(start_conv_o), 0);
        check("t1_busy_conv", 32'(busy_o), 1);
        step(97);
        drive_done(6'h2A, 12'h5C3, 1'b1);
        step(1);
        check("t1_valid_early", 32'(res_valid_o), 0);
        step(1);
        check("t1_valid", 32'(res_valid_o), 1);
        check("t1_busy_done", 32'(busy_o), 0);
        conv_done_i = 1'b0;
        ack();
        check("t1_ack", 32'(res_valid_o), 0);

        // Periodic mode: start spacing and overrun.
        period_i = 16'd50;
        en_i     = 1'b1;
        respond(6'h11, 12'h111, t_a);
        check("t2_valid1", 32'(res_valid_o), 1);
        check("t2_ovr0", 32'(overrun_o), 0);
        respond(6'h22, 12'h222, t_b);
        check("t2_period", 32'(t_b - t_a), 50);
        check("t2_valid2", 32'(res_valid_o), 1);
        check("t2_ovr1", 32'(overrun_o), 1);
        en_i = 1'b0;
        ack();
        check("t2_ack_valid", 32'(res_valid_o), 0);
        check("t2_ack_ovr", 32'(overrun_o), 0);
        step(2);
        check("t2_idle_busy", 32'(busy_o), 0);

        // Timeout with done held low, then cleared by a good conversion.
        pulse_single();
        wait_start_fall();
        n = 0;
        while (!timeout_o && n < 5000) begin
            step(1);
            n++;
        end
        check("t3_to_cycles", 32'(n), TIMEOUT);
        check("t3_to_valid", 32'(res_valid_o), 0);
        check("t3_to_busy", 32'(busy_o), 0);
        pulse_single();
        check("t3_to_held", 32'(timeout_o), 1);
        wait_start_fall();
        step(5);
        drive_done(6'h05, 12'h0AB, 1'b1);
        step(2);
        check("t3_to_clr", 32'(timeout_o), 0);
        check("t3_valid", 32'(res_valid_o), 1);
        conv_done_i = 1'b0;
        ack();

        // Done already high on entry is not an edge.
        conv_done_i = 1'b1;
        pulse_single();
        wait_start_fall();
        step(20);
        check("t4_no_cap", 32'(res_valid_o), 0);
        check("t4_busy", 32'(busy_o), 1);
        conv_done_i = 1'b0;
        step(3);
        drive_done(6'h3F, 12'hFFF, 1'b1);
        step(2);
        check("t4_valid", 32'(res_valid_o), 1);
        conv_done_i = 1'b0;

        // Async reset mid-CONV (with a result pending) and during the start pulse.
        pulse_single();
        wait_start_fall();
        step(5);
        #2 rst_n_i = 1'b0;
        #1 check_all_zero("t5_conv");
        step(2);
        rst_n_i = 1'b1;
        step(1);
        pulse_single();
        check("t5_pre_start", 32'(start_conv_o), 1);
        #2 rst_n_i = 1'b0;
        #1 check("t5_start_drop", 32'(start_conv_o), 0);
        check("t5_busy_drop", 32'(busy_o), 0);
        step(1);
        rst_n_i = 1'b1;
        step(1);
        pulse_single();
        wait_start_fall();
        step(8);
        drive_done(6'h15, 12'h3C4, 1'b1);
        step(2);
        check("t5_valid", 32'(res_valid_o), 1);
        conv_done_i = 1'b0;
        ack();
        check("t5_ack", 32'(res_valid_o), 0);
`endif

        step(2);
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
